// File: rtl/hit_detect_pkg.sv
// Shared constants and FSM encoding for the whack-a-mole hit detector.
package hit_detect_pkg;

  localparam int NUM_HOLES = 9;
  localparam int SCORE_W   = 8;
  localparam int MISS_W    = 4;
  localparam int POS_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

endpackage

// File: rtl/hit_detect_toggle_detect.sv
// Switch edge detector: remembers last switch levels and flags any bit that changed.
// With load_only set the history still tracks the switches but no toggle is reported.
module toggle_detect #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         load_only,
  input  logic [W-1:0] sw,
  output logic [W-1:0] tog
);

  logic [W-1:0] sw_prev;

  // History loads unconditionally, so reset and idle both reduce to masking the output.
  always_ff @(posedge clk) begin
    sw_prev <= sw;
  end

  assign tog = load_only ? '0 : (sw ^ sw_prev);

endmodule

// File: rtl/hit_detect.sv
// Judges switch toggles against the shown mole: registered hit/miss/ack pulses one cycle after
// the switch edge, plus saturating per-round hit and miss counters.
module hit_detect
  import hit_detect_pkg::*;
#(
  parameter int HOLES = NUM_HOLES,
  parameter int SW    = SCORE_W,
  parameter int MW    = MISS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_active,
  input  logic             mole_valid,
  input  logic [POS_W-1:0] mole_pos,
  input  logic [HOLES-1:0] sw_clean,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic             mole_ack,
  output logic [SW-1:0]    score,
  output logic [MW-1:0]    miss_cnt
);

  localparam logic [POS_W-1:0] HOLES_P = POS_W'(HOLES);

  state_t           state, state_nxt;
  logic [POS_W-1:0] pos_lat;
  logic [HOLES-1:0] tog;
  logic             mole_ok, any_tog, tgt_tog;
  logic             hit_nxt, miss_nxt, clr_nxt;

  toggle_detect #(.W(HOLES)) u_tog (
    .clk       (clk),
    .load_only (rst || (state == ST_IDLE)),
    .sw        (sw_clean),
    .tog       (tog)
  );

  assign mole_ok = mole_valid && (mole_pos < HOLES_P);
  assign any_tog = |tog;
  // Index only when in range; the && keeps an out-of-range position from reading garbage.
  assign tgt_tog = mole_ok && tog[mole_pos];

  always_comb begin
    state_nxt = state;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    if (!game_active) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_WAIT;
          clr_nxt   = 1'b1;
        end
        ST_WAIT: begin
          miss_nxt = any_tog;
          if (mole_ok) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (!mole_ok) begin
            miss_nxt  = any_tog;
            state_nxt = ST_WAIT;
          end else if (tgt_tog) begin
            hit_nxt   = 1'b1;
            state_nxt = ST_LOCKED;
          end else begin
            miss_nxt = any_tog;
          end
        end
        ST_LOCKED: begin
          if (!mole_valid || (mole_pos != pos_lat))
            state_nxt = mole_ok ? ST_ARMED : ST_WAIT;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pos_lat    <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      mole_ack   <= 1'b0;
      score      <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      hit_pulse  <= hit_nxt;
      miss_pulse <= miss_nxt;
      mole_ack   <= hit_nxt;
      if (hit_nxt) pos_lat <= mole_pos;
      if (clr_nxt) begin
        score    <= '0;
        miss_cnt <= '0;
      end else begin
        if (hit_nxt && (score != '1))     score    <= score + 1'b1;
        if (miss_nxt && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hit_detect.sv
// Directed bench for hit_detect with a per-cycle reference model and literal spot checks.
module tb_hit_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_active;
  logic       mole_valid;
  logic [3:0] mole_pos;
  logic [8:0] sw_clean;
  logic       hit_pulse, miss_pulse, mole_ack;
  logic [7:0] score;
  logic [3:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  hit_detect dut (
    .clk         (clk),
    .rst         (rst),
    .game_active (game_active),
    .mole_valid  (mole_valid),
    .mole_pos    (mole_pos),
    .sw_clean    (sw_clean),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .mole_ack    (mole_ack),
    .score       (score),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a round is either off, waiting for a mole to be seen for a cycle,
  // ready to judge, or holding a position that was already hit.
  logic [8:0] m_prev;
  bit         in_round, armed;
  int         hit_at;
  bit         e_hit, e_miss;
  int         e_score, e_misses;

  always @(posedge clk) begin
    logic [8:0] tg;
    bit         mok;
    tg     = sw_clean ^ m_prev;
    m_prev = sw_clean;
    mok    = mole_valid && (mole_pos < 4'd9);
    e_hit  = 0;
    e_miss = 0;
    if (rst) begin
      in_round = 0; armed = 0; hit_at = -1; e_score = 0; e_misses = 0;
    end else if (!game_active) begin
      in_round = 0;
    end else if (!in_round) begin
      in_round = 1; armed = 0; hit_at = -1; e_score = 0; e_misses = 0;
    end else if (hit_at >= 0) begin
      if (!mole_valid || (int'(mole_pos) != hit_at)) begin
        hit_at = -1;
        armed  = mok;
      end
    end else if (!armed) begin
      e_miss = (tg != 0);
      armed  = mok;
    end else if (!mok) begin
      e_miss = (tg != 0);
      armed  = 0;
    end else if (tg[mole_pos]) begin
      e_hit  = 1;
      hit_at = int'(mole_pos);
    end else begin
      e_miss = (tg != 0);
    end
    if (e_hit && e_score < 255) e_score++;
    if (e_miss && e_misses < 15) e_misses++;
  end

  always @(posedge clk) begin
    #1;
    chk("m_hit",   int'(hit_pulse),  int'(e_hit));
    chk("m_ack",   int'(mole_ack),   int'(e_hit));
    chk("m_miss",  int'(miss_pulse), int'(e_miss));
    chk("m_score", int'(score),      e_score);
    chk("m_mcnt",  int'(miss_cnt),   e_misses);
  end

  task automatic step(input logic r, input logic [8:0] s, input logic ga,
                      input logic mv, input logic [3:0] p);
    @(negedge clk);
    rst = r; sw_clean = s; game_active = ga; mole_valid = mv; mole_pos = p;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] s;
    logic [3:0] p;
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] s;
    logic [3:0] p;
    rst = 1; sw_clean = 9'h1FF; game_active = 1; mole_valid = 0; mole_pos = 0;
    look(); look();
    // 1: reset state
    chk("rst_hit", int'(hit_pulse), 0);
    chk("rst_miss", int'(miss_pulse), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_mcnt", int'(miss_cnt), 0);

    // 2: hit at hole 4, then repeat toggle while locked
    s = 9'h1FF;
    step(0, s, 1, 0, 0); look();
    step(0, s, 1, 1, 4); look();
    s[4] = ~s[4];
    step(0, s, 1, 1, 4); look();
    chk("hit4_pulse", int'(hit_pulse), 1);
    chk("hit4_ack", int'(mole_ack), 1);
    chk("hit4_score", int'(score), 1);
    look();
    chk("hit4_once", int'(hit_pulse), 0);
    s[4] = ~s[4];
    step(0, s, 1, 1, 4); look();
    chk("locked_hit", int'(hit_pulse), 0);
    chk("locked_miss", int'(miss_pulse), 0);
    chk("locked_score", int'(score), 1);

    // 3: wrong hole, then target plus another hole together
    step(0, s, 1, 1, 2); look();
    s[7] = ~s[7];
    step(0, s, 1, 1, 2); look();
    chk("miss7_pulse", int'(miss_pulse), 1);
    chk("miss7_cnt", int'(miss_cnt), 1);
    s = s ^ 9'h024;
    step(0, s, 1, 1, 2); look();
    chk("dual_hit", int'(hit_pulse), 1);
    chk("dual_nomiss", int'(miss_pulse), 0);
    chk("dual_score", int'(score), 2);
    chk("dual_mcnt", int'(miss_cnt), 1);

    // 4: out-of-range position counts as no mole
    step(0, s, 1, 1, 9); look();
    s[0] = ~s[0];
    step(0, s, 1, 1, 9); look();
    chk("pos9_miss", int'(miss_pulse), 1);
    chk("pos9_nohit", int'(hit_pulse), 0);
    chk("pos9_mcnt", int'(miss_cnt), 2);

    // 5: saturate both counters
    for (int i = 0; i < 260; i++) begin
      p = (i % 2 == 1) ? 4'd3 : 4'd6;
      step(0, s, 1, 1, p); look();
      s[p] = ~s[p];
      step(0, s, 1, 1, p); look();
    end
    chk("sat_hit", int'(hit_pulse), 1);
    chk("sat_score", int'(score), 255);
    step(0, s, 1, 1, 9); look();
    for (int i = 0; i < 16; i++) begin
      s[0] = ~s[0];
      step(0, s, 1, 1, 9); look();
    end
    chk("sat_miss", int'(miss_pulse), 1);
    chk("sat_mcnt", int'(miss_cnt), 15);

    // 6: round ends, switches move while idle, new round clears counters
    step(0, s, 0, 1, 9); look();
    chk("idle_score", int'(score), 255);
    chk("idle_mcnt", int'(miss_cnt), 15);
    s = s ^ 9'h0F3;
    step(0, s, 0, 1, 9); look();
    chk("idle_nomiss", int'(miss_pulse), 0);
    step(0, s, 1, 1, 9); look();
    chk("new_score", int'(score), 0);
    chk("new_mcnt", int'(miss_cnt), 0);
    look();
    chk("new_nomiss", int'(miss_pulse), 0);

    // Reset mid-round discards a toggle presented with it
    s[1] = ~s[1];
    step(1, s, 1, 1, 1); look();
    chk("rstmid_miss", int'(miss_pulse), 0);
    chk("rstmid_hit", int'(hit_pulse), 0);
    step(0, s, 1, 1, 1); look(); look();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
